// File: rtl/mem_req_throttle_pkg.sv
// Shared DRAM request/response types and default widths for the memory-side
// request throttle and its neighbours.
package mem_req_throttle_pkg;

    localparam int DRAM_DATA_WIDTH = 128;
    localparam int DRAM_ADDR_WIDTH = 28;
    localparam int DRAM_TAG_WIDTH  = 8;
    localparam int DRAM_BE_WIDTH   = DRAM_DATA_WIDTH / 8;

    typedef struct packed {
        logic                       rw;
        logic [DRAM_BE_WIDTH-1:0]   byteen;
        logic [DRAM_ADDR_WIDTH-1:0] addr;
        logic [DRAM_DATA_WIDTH-1:0] data;
        logic [DRAM_TAG_WIDTH-1:0]  tag;
    } dram_req_t;

    typedef struct packed {
        logic [DRAM_DATA_WIDTH-1:0] data;
        logic [DRAM_TAG_WIDTH-1:0]  tag;
    } dram_rsp_t;

endpackage

// File: rtl/mem_req_throttle_if.sv
// DRAM request/response channel. The master issues requests and accepts
// responses; the slave accepts requests and returns responses.
interface mem_req_throttle_if
    import mem_req_throttle_pkg::*;
#(
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH,
    parameter int TAG_WIDTH  = DRAM_TAG_WIDTH
);
    logic                    req_valid;
    logic                    req_rw;
    logic [DATA_WIDTH/8-1:0] req_byteen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    req_ready;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [TAG_WIDTH-1:0]    rsp_tag;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
        output req_ready,
        output rsp_valid, rsp_data, rsp_tag,
        input  rsp_ready
    );

endinterface

// File: rtl/mem_req_throttle_stage.sv
// Generic one-entry valid/ready register with pipe-ready semantics: it accepts
// whenever it is empty or being drained this cycle, gated by an enable.
module pipe_reg_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_out
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             stage_free_s;
    logic             fire_s;

    assign stage_free_s = !valid_q || ready_out;
    assign ready_in     = enable && stage_free_s;
    assign fire_s       = valid_in && ready_in;
    assign valid_out    = valid_q;
    assign data_out     = data_q;

    // Next-state: load on accept, clear on drain, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (fire_s) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (ready_out) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid flag register, cleared by reset so an in-flight entry is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register; contents are meaningless while valid_q is low.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/mem_req_throttle.sv
// Caps outstanding DRAM reads, registers the request path through one
// pipe stage, passes responses straight through and exports perf counters.
module mem_req_throttle
    import mem_req_throttle_pkg::*;
#(
    parameter int   DATA_WIDTH  = DRAM_DATA_WIDTH,
    parameter int   ADDR_WIDTH  = DRAM_ADDR_WIDTH,
    parameter int   TAG_WIDTH   = DRAM_TAG_WIDTH,
    parameter int   MAX_PENDING = 8,
    localparam int  CNT_WIDTH   = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_req_throttle_if.slave     core,
    mem_req_throttle_if.master    dram,
    output logic [CNT_WIDTH-1:0]  pending_count,
    output logic [31:0]           stall_cycles,
    output logic                  underflow_err
);

    localparam int REQ_W = 1 + DATA_WIDTH / 8 + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PENDING);

    logic [REQ_W-1:0]     stage_in_s;
    logic [REQ_W-1:0]     stage_out_s;
    logic                 stage_valid_s;
    logic                 req_ready_s;
    logic                 rd_ok_s;
    logic                 fire_in_s;
    logic                 inc_s;
    logic                 dec_s;

    logic [CNT_WIDTH-1:0] pending_q;
    logic [CNT_WIDTH-1:0] pending_d;
    logic [31:0]          stall_q;
    logic [31:0]          stall_d;
    logic                 underflow_q;
    logic                 underflow_d;

    // Throttle only looks at the registered count, so responses never reach req_ready.
    assign rd_ok_s    = core.req_rw || (pending_q < MAX_CNT);
    assign fire_in_s  = core.req_valid && req_ready_s;
    assign inc_s      = fire_in_s && !core.req_rw;
    assign dec_s      = dram.rsp_valid && core.rsp_ready;

    assign stage_in_s = {core.req_rw, core.req_byteen, core.req_addr,
                         core.req_data, core.req_tag};

    pipe_reg_stage #(
        .WIDTH (REQ_W)
    ) u_req_stage (
        .clk       (clk),
        .reset     (reset),
        .enable    (rd_ok_s),
        .valid_in  (core.req_valid),
        .ready_in  (req_ready_s),
        .data_in   (stage_in_s),
        .valid_out (stage_valid_s),
        .data_out  (stage_out_s),
        .ready_out (dram.req_ready)
    );

    assign core.req_ready = req_ready_s;
    assign dram.req_valid = stage_valid_s;
    assign {dram.req_rw, dram.req_byteen, dram.req_addr,
            dram.req_data, dram.req_tag} = stage_out_s;

    assign core.rsp_valid = dram.rsp_valid;
    assign core.rsp_data  = dram.rsp_data;
    assign core.rsp_tag   = dram.rsp_tag;
    assign dram.rsp_ready = core.rsp_ready;

    // Pending-read counter, sticky underflow flag and stall statistics.
    always_comb begin
        pending_d   = pending_q;
        underflow_d = underflow_q;
        stall_d     = stall_q;
        case ({inc_s, dec_s})
            2'b10: pending_d = pending_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            2'b01: begin
                if (pending_q == {CNT_WIDTH{1'b0}}) begin
                    underflow_d = 1'b1;
                end else begin
                    pending_d = pending_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: pending_d = pending_q;
        endcase
        if (core.req_valid && !req_ready_s) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= {CNT_WIDTH{1'b0}};
            stall_q     <= 32'd0;
            underflow_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            stall_q     <= stall_d;
            underflow_q <= underflow_d;
        end
    end

    assign pending_count = pending_q;
    assign stall_cycles  = stall_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_mem_req_throttle.sv
// Scoreboard bench for mem_req_throttle: a cycle model predicts ready, the
// counters and the expected output-stage payload.
module tb_mem_req_throttle;
    import mem_req_throttle_pkg::*;

    localparam int MAXP = 8;
    localparam int CW   = $clog2(MAXP + 1);

    logic          clk;
    logic          reset;
    logic [CW-1:0] pending_count;
    logic [31:0]   stall_cycles;
    logic          underflow_err;

    mem_req_throttle_if core_if ();
    mem_req_throttle_if dram_if ();

    mem_req_throttle #(.MAX_PENDING(MAXP)) dut (
        .clk           (clk),
        .reset         (reset),
        .core          (core_if.slave),
        .dram          (dram_if.master),
        .pending_count (pending_count),
        .stall_cycles  (stall_cycles),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    dram_req_t   exp_q[$];
    logic        m_vout;
    int          m_pend;
    logic        m_uf;
    logic [31:0] m_stall;
    logic        m_last_fire;
    int          n_acc;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_idle();
        core_if.req_valid  = 1'b0;
        core_if.req_rw     = 1'b0;
        core_if.req_byteen = '0;
        core_if.req_addr   = '0;
        core_if.req_data   = '0;
        core_if.req_tag    = '0;
        core_if.rsp_ready  = 1'b1;
        dram_if.req_ready  = 1'b1;
        dram_if.rsp_valid  = 1'b0;
        dram_if.rsp_data   = '0;
        dram_if.rsp_tag    = '0;
    endtask

    task automatic set_req(input logic rw, input logic [27:0] addr, input logic [7:0] tag);
        core_if.req_valid  = 1'b1;
        core_if.req_rw     = rw;
        core_if.req_addr   = addr;
        core_if.req_tag    = tag;
        core_if.req_byteen = {addr[7:0], tag};
        core_if.req_data   = {4{addr, tag[3:0]}};
    endtask

    // One clock: called just after a falling edge with inputs already applied.
    task automatic cycle();
        logic      rdy, fire, inc, dec;
        dram_req_t cur;
        #1;
        rdy = (!m_vout || dram_if.req_ready) && (core_if.req_rw || (m_pend < MAXP));
        check("req_ready_in", core_if.req_ready, rdy);
        check("rsp_valid_out", core_if.rsp_valid, dram_if.rsp_valid);
        check("rsp_tag_out", core_if.rsp_tag, dram_if.rsp_tag);
        check("rsp_data_out", core_if.rsp_data, dram_if.rsp_data);
        check("rsp_ready_in", dram_if.rsp_ready, core_if.rsp_ready);
        if (m_vout && exp_q.size() > 0) begin
            cur = {dram_if.req_rw, dram_if.req_byteen, dram_if.req_addr,
                   dram_if.req_data, dram_if.req_tag};
            check("req_out_payload", cur, exp_q[0]);
        end
        fire = core_if.req_valid && rdy;
        if (m_vout && dram_if.req_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (fire) begin
            exp_q.push_back({core_if.req_rw, core_if.req_byteen, core_if.req_addr,
                             core_if.req_data, core_if.req_tag});
            n_acc++;
        end
        inc = fire && !core_if.req_rw;
        dec = dram_if.rsp_valid && core_if.rsp_ready;
        if (inc && !dec) m_pend++;
        else if (dec && !inc) begin
            if (m_pend == 0) m_uf = 1'b1;
            else m_pend--;
        end
        if (core_if.req_valid && !rdy) m_stall = m_stall + 32'd1;
        m_vout      = fire ? 1'b1 : (dram_if.req_ready ? 1'b0 : m_vout);
        m_last_fire = fire;
        @(posedge clk);
        #1;
        check("req_valid_out", dram_if.req_valid, m_vout);
        check("pending_count", pending_count, m_pend[CW-1:0]);
        check("underflow_err", underflow_err, m_uf);
        check("stall_cycles", stall_cycles, m_stall);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        m_vout  = 1'b0;
        m_pend  = 0;
        m_uf    = 1'b0;
        m_stall = 32'd0;
        exp_q.delete();
        check("rst_req_valid_out", dram_if.req_valid, 1'b0);
        check("rst_pending_count", pending_count, 0);
        check("rst_underflow_err", underflow_err, 1'b0);
        check("rst_stall_cycles", stall_cycles, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int acc0;
        reset = 1'b1;
        m_last_fire = 1'b0;
        n_acc = 0;
        drive_idle();
        @(negedge clk);
        do_reset();

        // Single read then its response
        set_req(1'b0, 28'h123, 8'd5);
        cycle();
        drive_idle();
        cycle();
        check("single_pending", pending_count, 1);
        dram_if.rsp_valid = 1'b1;
        dram_if.rsp_tag   = 8'd5;
        dram_if.rsp_data  = {4{32'hCAFE_0005}};
        cycle();
        check("single_pending_after_rsp", pending_count, 0);
        drive_idle();
        cycle();

        // Saturation: 12 cycles of read requests, only MAXP may be accepted
        acc0 = n_acc;
        for (int i = 0; i < 12; i++) begin
            set_req(1'b0, 28'h1000 + 28'(n_acc), 8'(n_acc));
            cycle();
        end
        check("sat_accepted", n_acc - acc0, MAXP);
        check("sat_pending", pending_count, MAXP);
        check("sat_ready_low", core_if.req_ready, 1'b0);
        check("sat_stall", stall_cycles, 4);
        dram_if.rsp_valid = 1'b1;
        cycle();
        check("sat_same_cycle_not_freed", n_acc - acc0, MAXP);
        dram_if.rsp_valid = 1'b0;
        cycle();
        check("sat_ninth_accepted", n_acc - acc0, MAXP + 1);

        // Write under saturation is accepted and not counted
        set_req(1'b1, 28'h2000, 8'hA0);
        cycle();
        check("wr_sat_accepted", m_last_fire, 1'b1);
        check("wr_sat_pending", pending_count, MAXP);

        // Backpressure: stage full, DRAM not ready for 5 cycles
        dram_if.req_ready = 1'b0;
        set_req(1'b1, 28'h2001, 8'hA1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_ready_low", core_if.req_ready, 1'b0);
            check("bp_hold_addr", dram_if.req_addr, 28'h2000);
        end
        dram_if.req_ready = 1'b1;
        cycle();
        check("bp_accept_on_drain", m_last_fire, 1'b1);
        drive_idle();
        cycle();

        // Simultaneous inc/dec at pending_count==3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 28'h3000 + 28'(i), 8'(i));
            cycle();
        end
        set_req(1'b0, 28'h3003, 8'd3);
        dram_if.rsp_valid = 1'b1;
        dram_if.rsp_tag   = 8'd0;
        cycle();
        check("incdec_pending", pending_count, 3);
        drive_idle();
        cycle();

        // Underflow, then reset with a held output request
        do_reset();
        dram_if.rsp_valid = 1'b1;
        cycle();
        check("uf_flag", underflow_err, 1'b1);
        check("uf_count", pending_count, 0);
        drive_idle();
        dram_if.req_ready = 1'b0;
        set_req(1'b0, 28'h4000, 8'h44);
        cycle();
        core_if.req_valid = 1'b0;
        cycle();
        check("pre_rst_valid", dram_if.req_valid, 1'b1);
        do_reset();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (!core_if.req_valid || m_last_fire) begin
                if ($urandom_range(0, 3) != 0)
                    set_req(1'($urandom_range(0, 3) == 0), 28'($urandom), 8'($urandom));
                else
                    core_if.req_valid = 1'b0;
            end
            dram_if.req_ready = ($urandom_range(0, 3) != 0);
            core_if.rsp_ready = ($urandom_range(0, 4) != 0);
            dram_if.rsp_valid = (m_pend > 0) && ($urandom_range(0, 2) == 0);
            dram_if.rsp_tag   = 8'($urandom);
            dram_if.rsp_data  = {4{32'($urandom)}};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
